cpu_controlunit_seq: RTL and testbench
======================================

// Module: cpu_controlunit_seq
// PURPOSE
//  Multi-cycle sequencing control unit for the SlimProc CPU; replaces the single-cycle opcode decoder.
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on a memory ready handshake,
//  and takes maskable interrupts at instruction boundaries. Drives datapath, ALU and memory strobes.
// PARAMETERS
//  OPCODE_W   8    opcode width; only low 8 bits decoded, nonzero upper bits = illegal
//  ALU_OP_W   16   alu_opcode width (>=8)
//  IRQ_VECTOR 0    value driven on vector_out during IRQ entry (32 bits)
// PORTS
//  clk         in   1         clock, rising edge
//  reset       in   1         asynchronous, active-high
//  interrupt   in   1         level interrupt request
//  opcode      in   OPCODE_W  opcode field of instruction register
//  mem_ready   in   1         memory completed current read/write this cycle
//  alu_zero    in   1         ALU zero flag for branch resolution
//  alu_opcode  out  ALU_OP_W  ALU operation
//  ir_load, pc_write, jump, reg_dst, reg_write, mem_read, mem_write, memtoreg, beq, bne  out 1 each
//  irq_ack     out  1         one-cycle pulse on IRQ entry
//  vector_out  out  32        IRQ_VECTOR, valid while irq_ack
//  illegal     out  1         sticky illegal-opcode flag
// BEHAVIOUR
//  Reset (async, any state): state=FETCH, ie=0, illegal=0, latched opcode=0; all outputs 0,
//   alu_opcode=0x0011 (NOP). Mid-instruction reset abandons instruction; no strobe survives.
//  Opcode latched in DECODE; EXEC/MEM/WB decode only the latched copy.
//  Outputs Moore-style from state + latched opcode; valid in the state's cycle.
//  FETCH: mem_read=1, ir_load=mem_ready; stay until mem_ready, then DECODE.
//  DECODE: 1 cycle, latches opcode; illegal -> set illegal, treat as NOP.
//  EXEC: alu_opcode per op (ADD 0x0000, SUB 0x0001, AND 0x0002, OR 0x0003, else 0x0011).
//   ALU ops -> WB. LD 0x10/ST 0x11 -> MEM. Branch/jump/EI/DI/NOP -> boundary.
//   BEQ 0x20: beq=1, pc_write=alu_zero. BNE 0x21: bne=1, pc_write=!alu_zero. JMP 0x22: jump=1, pc_write=1.
//   EI 0x30 sets ie; DI 0x31 clears ie, effective next cycle.
//  MEM: LD mem_read=1, ST mem_write=1, held until mem_ready; LD -> WB, ST -> boundary.
//  WB: reg_write=1; reg_dst=1 for ALU ops, 0 for LD; memtoreg=1 for LD.
//  Boundary (exit of EXEC/MEM/WB ending an instr): interrupt&&ie -> IRQ else FETCH.
//  IRQ: 1 cycle; irq_ack=1, jump=1, pc_write=1, ie<=0 -> FETCH. No re-entry until EI.
//  EI + pending interrupt in same instr: ie update wins after EXEC, so IRQ taken at that boundary.
//  Sequential instrs (no stall): ALU 4 cycles, LD 5, ST 4, branch/misc 3, IRQ +1.
//  mem_ready outside FETCH/MEM ignored. Zero-wait mem_ready=1 legal.
//  Only one of mem_read/mem_write high per cycle; reg_write never with mem_write.
// STRUCTURE
//  Package cpu_pkg: opcode localparams, ALU op codes, 3-bit state encoding
//   (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, IRQ=5); unused codes recover to FETCH.
//  Sub-module cpu_controlunit_decode: combinational latched-opcode -> class/alu_opcode/illegal.
//  Top: state register, ie, illegal, opcode latch, output mux.
// TESTING
//  Reset mid-MEM of LD (mem_read=1) -> next cycle all strobes 0, state FETCH, alu_opcode=0x0011.
//  ADD (0x01), mem_ready=1 always -> reg_write=1 with reg_dst=1 on cycle 4, alu_opcode=0x0000 cycle 3.
//  LD (0x10), mem_ready low 3 MEM cycles -> mem_read held 4 cycles, then WB memtoreg=1.
//  BEQ alu_zero=1 -> pc_write=1 in EXEC; BNE alu_zero=1 -> pc_write=0.
//  interrupt=1, ie=0 -> no irq_ack; EI then ADD -> irq_ack 1 cycle after ADD's WB, ie=0 after.
//  opcode 0xFF -> illegal=1 sticky, no reg_write/mem_write, FETCH resumes; cleared only by reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the SlimProc multi-cycle control unit:
// sequencer states, opcode map, instruction classes and ALU op codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IRQ    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NOP,
    C_ALU,
    C_LD,
    C_ST,
    C_BEQ,
    C_BNE,
    C_JMP,
    C_EI,
    C_DI
  } cls_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_LD  = 8'h10;
  localparam logic [7:0] OP_ST  = 8'h11;
  localparam logic [7:0] OP_BEQ = 8'h20;
  localparam logic [7:0] OP_BNE = 8'h21;
  localparam logic [7:0] OP_JMP = 8'h22;
  localparam logic [7:0] OP_EI  = 8'h30;
  localparam logic [7:0] OP_DI  = 8'h31;

  localparam logic [15:0] ALU_ADD = 16'h0000;
  localparam logic [15:0] ALU_SUB = 16'h0001;
  localparam logic [15:0] ALU_AND = 16'h0002;
  localparam logic [15:0] ALU_OR  = 16'h0003;
  localparam logic [15:0] ALU_NOP = 16'h0011;

  function automatic logic op_known(input logic [7:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_JMP,
      OP_EI, OP_DI: op_known = 1'b1;
      default:      op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_controlunit_decode.sv
// Combinational decode of the latched opcode into an instruction
// class and ALU operation; unknown or wide opcodes decode as NOP.
module cpu_controlunit_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] op,
  output cls_t                cls,
  output logic [15:0]         alu_op,
  output logic                illegal
);

  logic hi_bad;

  assign hi_bad = (op >> 8) != '0;

  always_comb begin
    cls     = C_NOP;
    alu_op  = ALU_NOP;
    illegal = 1'b0;
    case (op[7:0])
      OP_ADD: begin cls = C_ALU; alu_op = ALU_ADD; end
      OP_SUB: begin cls = C_ALU; alu_op = ALU_SUB; end
      OP_AND: begin cls = C_ALU; alu_op = ALU_AND; end
      OP_OR:  begin cls = C_ALU; alu_op = ALU_OR;  end
      OP_LD:  cls = C_LD;
      OP_ST:  cls = C_ST;
      OP_BEQ: cls = C_BEQ;
      OP_BNE: cls = C_BNE;
      OP_JMP: cls = C_JMP;
      OP_EI:  cls = C_EI;
      OP_DI:  cls = C_DI;
      OP_NOP: cls = C_NOP;
      default: illegal = 1'b1;
    endcase
    if (hi_bad) begin
      cls     = C_NOP;
      alu_op  = ALU_NOP;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_controlunit_seq.sv
// SlimProc multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// stalls and maskable interrupts taken at instruction boundaries.
module cpu_controlunit_seq
  import cpu_pkg::*;
#(
  parameter int          OPCODE_W   = 8,
  parameter int          ALU_OP_W   = 16,
  parameter logic [31:0] IRQ_VECTOR = 32'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                interrupt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                ir_load,
  output logic                pc_write,
  output logic                jump,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                memtoreg,
  output logic                beq,
  output logic                bne,
  output logic                irq_ack,
  output logic [31:0]         vector_out,
  output logic                illegal
);

  state_t                state_q, state_d;
  logic                  ie_q, ie_d;
  logic                  illegal_q, illegal_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  cls_t                  cls;
  logic [15:0]           dec_alu;
  logic                  dec_ill;
  logic                  live_ill;
  logic                  boundary;

  cpu_controlunit_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .op      (op_q),
    .cls     (cls),
    .alu_op  (dec_alu),
    .illegal (dec_ill)
  );

  assign live_ill = !op_known(opcode[7:0]) || ((opcode >> 8) != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ie_q      <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    illegal_d  = illegal_q;
    op_d       = op_q;
    boundary   = 1'b0;
    alu_opcode = ALU_OP_W'(ALU_NOP);
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    memtoreg   = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    irq_ack    = 1'b0;
    vector_out = 32'd0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_load  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXEC;
        if (live_ill) illegal_d = 1'b1;
      end
      S_EXEC: begin
        alu_opcode = ALU_OP_W'(dec_alu);
        case (cls)
          C_ALU: state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          C_BEQ: begin
            beq      = 1'b1;
            pc_write = alu_zero;
            boundary = 1'b1;
          end
          C_BNE: begin
            bne      = 1'b1;
            pc_write = !alu_zero;
            boundary = 1'b1;
          end
          C_JMP: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            boundary = 1'b1;
          end
          C_EI: begin
            ie_d     = 1'b1;
            boundary = 1'b1;
          end
          C_DI: begin
            ie_d     = 1'b0;
            boundary = 1'b1;
          end
          default: boundary = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls == C_LD);
        mem_write = (cls != C_LD);
        if (mem_ready) begin
          if (cls == C_LD) state_d = S_WB;
          else             boundary = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (cls == C_ALU);
        memtoreg  = (cls == C_LD);
        boundary  = 1'b1;
      end
      S_IRQ: begin
        irq_ack    = 1'b1;
        jump       = 1'b1;
        pc_write   = 1'b1;
        vector_out = IRQ_VECTOR;
        ie_d       = 1'b0;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // EI/DI in this EXEC already count when deciding the boundary
    if (boundary) state_d = (interrupt && ie_d) ? S_IRQ : S_FETCH;
    if (reset) begin
      alu_opcode = ALU_OP_W'(ALU_NOP);
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      jump       = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      memtoreg   = 1'b0;
      beq        = 1'b0;
      bne        = 1'b0;
      irq_ack    = 1'b0;
      vector_out = 32'd0;
    end
  end

  assign illegal = illegal_q & ~reset;

  logic unused_dec;
  assign unused_dec = dec_ill;

endmodule

// File: tb/tb_cpu_controlunit_seq.sv
// Directed cycle-by-cycle check of the SlimProc sequencer outputs.
module tb_cpu_controlunit_seq;

  localparam logic [31:0] VEC = 32'hDEAD_BEEF;

  localparam logic [11:0] F_IRQ  = 12'h800;
  localparam logic [11:0] F_IRL  = 12'h400;
  localparam logic [11:0] F_PCW  = 12'h200;
  localparam logic [11:0] F_JMP  = 12'h100;
  localparam logic [11:0] F_RDST = 12'h080;
  localparam logic [11:0] F_RW   = 12'h040;
  localparam logic [11:0] F_MR   = 12'h020;
  localparam logic [11:0] F_MW   = 12'h010;
  localparam logic [11:0] F_M2R  = 12'h008;
  localparam logic [11:0] F_BEQ  = 12'h004;
  localparam logic [11:0] F_BNE  = 12'h002;
  localparam logic [11:0] F_ILL  = 12'h001;
  localparam logic [15:0] A_NOP  = 16'h0011;

  typedef struct {
    logic        intr;
    logic [7:0]  op;
    logic        rdy;
    logic        z;
    logic [11:0] flags;
    logic [15:0] alu;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        interrupt = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [15:0] alu_opcode;
  logic        ir_load, pc_write, jump, reg_dst, reg_write;
  logic        mem_read, mem_write, memtoreg, beq, bne;
  logic        irq_ack, illegal;
  logic [31:0] vector_out;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  logic [11:0] sticky;

  cpu_controlunit_seq #(
    .OPCODE_W(8), .ALU_OP_W(16), .IRQ_VECTOR(VEC)
  ) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .alu_opcode(alu_opcode), .ir_load(ir_load), .pc_write(pc_write),
    .jump(jump), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .memtoreg(memtoreg),
    .beq(beq), .bne(bne), .irq_ack(irq_ack), .vector_out(vector_out),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] got_flags();
    return {irq_ack, ir_load, pc_write, jump, reg_dst, reg_write,
            mem_read, mem_write, memtoreg, beq, bne, illegal};
  endfunction

  task automatic check(input string nm, input logic [11:0] ef,
                       input logic [15:0] ea);
    logic [31:0] ev;
    ev = ef[11] ? VEC : 32'd0;
    checks++;
    if (got_flags() !== ef || alu_opcode !== ea || vector_out !== ev) begin
      errors++;
      $display("FAIL %s: got flags=%h alu=%h vec=%h, need flags=%h alu=%h vec=%h",
               nm, got_flags(), alu_opcode, vector_out, ef, ea, ev);
    end
  endtask

  task automatic add(input logic i, input logic [7:0] op, input logic r,
                     input logic z, input logic [11:0] f, input logic [15:0] a);
    vec_t v;
    v.intr = i; v.op = op; v.rdy = r; v.z = z;
    v.flags = f | sticky; v.alu = a;
    tbl.push_back(v);
  endtask

  task automatic add3(input logic i, input logic [7:0] op, input logic z,
                      input logic [11:0] ef, input logic [15:0] ea);
    add(i, op, 1, z, F_MR | F_IRL, A_NOP);
    add(i, op, 1, z, 12'h000, A_NOP);
    add(i, op, 1, z, ef, ea);
  endtask

  task automatic add_alu(input logic i, input logic [7:0] op,
                         input logic [15:0] ea);
    add3(i, op, 0, 12'h000, ea);
    add(i, op, 1, 0, F_RDST | F_RW, A_NOP);
  endtask

  initial begin
    sticky = 12'h000;
    add_alu(0, 8'h01, 16'h0000);
    add_alu(0, 8'h02, 16'h0001);
    add(0, 8'h10, 0, 0, F_MR, A_NOP);
    add3(0, 8'h10, 0, 12'h000, A_NOP);
    add(0, 8'h10, 0, 0, F_MR, A_NOP);
    add(0, 8'h10, 0, 0, F_MR, A_NOP);
    add(0, 8'h10, 0, 0, F_MR, A_NOP);
    add(0, 8'h10, 1, 0, F_MR, A_NOP);
    add(0, 8'h10, 1, 0, F_RW | F_M2R, A_NOP);
    add3(0, 8'h11, 0, 12'h000, A_NOP);
    add(0, 8'h11, 1, 0, F_MW, A_NOP);
    add3(0, 8'h20, 1, F_BEQ | F_PCW, A_NOP);
    add3(0, 8'h20, 0, F_BEQ, A_NOP);
    add3(0, 8'h21, 1, F_BNE, A_NOP);
    add3(0, 8'h21, 0, F_BNE | F_PCW, A_NOP);
    add3(0, 8'h22, 0, F_JMP | F_PCW, A_NOP);
    add_alu(1, 8'h01, 16'h0000);
    add3(0, 8'h30, 0, 12'h000, A_NOP);
    add_alu(1, 8'h01, 16'h0000);
    add(1, 8'h00, 1, 0, F_IRQ | F_JMP | F_PCW, A_NOP);
    add3(1, 8'h00, 0, 12'h000, A_NOP);
    add3(1, 8'h30, 0, 12'h000, A_NOP);
    add(1, 8'h00, 1, 0, F_IRQ | F_JMP | F_PCW, A_NOP);
    add3(0, 8'h30, 0, 12'h000, A_NOP);
    add3(1, 8'h31, 0, 12'h000, A_NOP);
    add(0, 8'hFF, 1, 0, F_MR | F_IRL, A_NOP);
    add(0, 8'hFF, 1, 0, 12'h000, A_NOP);
    sticky = F_ILL;
    add(0, 8'hFF, 1, 0, 12'h000, A_NOP);
    add_alu(0, 8'h03, 16'h0002);
    add_alu(0, 8'h04, 16'h0003);

    repeat (2) @(negedge clk);
    #1 check("reset_state", 12'h000, A_NOP);
    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[k]) begin
      @(negedge clk);
      interrupt = tbl[k].intr;
      opcode    = tbl[k].op;
      mem_ready = tbl[k].rdy;
      alu_zero  = tbl[k].z;
      #1 check($sformatf("row%0d_op%h", k, tbl[k].op),
               tbl[k].flags, tbl[k].alu);
    end

    interrupt = 1'b0;
    @(negedge clk);
    opcode = 8'h10; mem_ready = 1'b1;
    #1 check("rst_ld_fetch", F_MR | F_IRL | F_ILL, A_NOP);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("rst_ld_exec", F_ILL, A_NOP);
    @(negedge clk);
    #1 check("rst_ld_mem", F_MR | F_ILL, A_NOP);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_async", 12'h000, A_NOP);
    @(negedge clk);
    #1 check("rst_held", 12'h000, A_NOP);
    reset = 1'b0;
    #1 check("rst_fetch", F_MR, A_NOP);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("rst_fetch_rdy", F_MR | F_IRL, A_NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
